// File: rtl/red_pitaya_cordic_rot_block.sv
// CORDIC rotator: turns (phase, amplitude) into I = amp*cos, Q = amp*sin.
// Latency: NSTAGES+2 cycles valid_i -> valid_o (NSTAGES+3 with gain compensation).
// Backpressure: none; fully pipelined, one sample per cycle, valid travels with data.
//
// Ports:
//   clk_i    - sole clock, rising edge
//   rstn_i   - asynchronous active-low reset; clears every pipeline register
//   phase_i  - unsigned phase, full turn = 2^PHASEWIDTH, counter-clockwise
//   amp_i    - signed amplitude
//   valid_i  - qualifies phase_i / amp_i
//   i_o/q_o  - signed, saturated in-phase / quadrature results
//   valid_o  - qualifies i_o / q_o
//
// Optional feature: define CORDIC_ROT_GAINCOMP_EN to add one pipeline stage that
// multiplies x/y by 28140/2^15 so the output magnitude equals |amp_i| instead of
// |amp_i| times the CORDIC gain (~1.1645). The angle table supports
// PHASEWIDTH <= 16 and NSTAGES <= 16.

module red_pitaya_cordic_rot_block #(
  parameter int SIGNALBITS   = 14,
  parameter int INPUTWIDTH   = 14,
  parameter int WORKINGWIDTH = 16,
  parameter int PHASEWIDTH   = 12,
  parameter int NSTAGES      = 9
) (
  input  logic                         clk_i,
  input  logic                         rstn_i,
  input  logic [PHASEWIDTH-1:0]        phase_i,
  input  logic signed [INPUTWIDTH-1:0] amp_i,
  input  logic                         valid_i,
  output logic signed [SIGNALBITS-1:0] i_o,
  output logic signed [SIGNALBITS-1:0] q_o,
  output logic                         valid_o
);

  // LSB padding applied to the amplitude inside the working width
  localparam int PAD = WORKINGWIDTH - INPUTWIDTH - 2;
  // residual phase needs one extra bit so the accumulated angle never wraps
  localparam int ZW  = PHASEWIDTH + 1;
  localparam int OW  = WORKINGWIDTH + SIGNALBITS;
  // alignment from the amplitude scale to the output sample scale
  localparam int UP  = (SIGNALBITS > INPUTWIDTH) ? SIGNALBITS - INPUTWIDTH : 0;
  localparam int DN  = (INPUTWIDTH > SIGNALBITS) ? INPUTWIDTH - SIGNALBITS : 0;

  localparam logic signed [OW-1:0] OMAX = OW'((2 ** (SIGNALBITS - 1)) - 1);
  localparam logic signed [OW-1:0] OMIN = OW'(-(2 ** (SIGNALBITS - 1)));

  // atan(2^-(k+1)) as a fraction of a full turn, floored at 16-bit resolution.
  // Flooring again by the right shift yields the floor at PHASEWIDTH resolution.
  function automatic logic signed [ZW-1:0] angle_of(input int k);
    logic [15:0] a16;
    case (k)
      0:       a16 = 16'd4836;
      1:       a16 = 16'd2555;
      2:       a16 = 16'd1297;
      3:       a16 = 16'd651;
      4:       a16 = 16'd325;
      5:       a16 = 16'd162;
      6:       a16 = 16'd81;
      7:       a16 = 16'd40;
      8:       a16 = 16'd20;
      9:       a16 = 16'd10;
      10:      a16 = 16'd5;
      11:      a16 = 16'd2;
      12:      a16 = 16'd1;
      default: a16 = 16'd0;
    endcase
    return ZW'(a16 >> (16 - PHASEWIDTH));
  endfunction

  // Scale a working-width value to the output sample width with saturation.
  function automatic logic signed [SIGNALBITS-1:0] scale_sat(
    input logic signed [WORKINGWIDTH-1:0] v
  );
    logic signed [OW-1:0]         w;
    logic signed [SIGNALBITS-1:0] r;
    w = {{SIGNALBITS{v[WORKINGWIDTH-1]}}, v};
    w = (w >>> (PAD + DN)) <<< UP;
    if (w > OMAX) begin
      r = OMAX[SIGNALBITS-1:0];
    end else if (w < OMIN) begin
      r = OMIN[SIGNALBITS-1:0];
    end else begin
      r = w[SIGNALBITS-1:0];
    end
    return r;
  endfunction

`ifdef CORDIC_ROT_GAINCOMP_EN
  localparam int GW = WORKINGWIDTH + 16;
  localparam logic signed [GW-1:0] GAIN = GW'(28140);
  localparam logic signed [GW-1:0] GMAX = GW'((2 ** (WORKINGWIDTH - 1)) - 1);
  localparam logic signed [GW-1:0] GMIN = GW'(-(2 ** (WORKINGWIDTH - 1)));

  // x * 28140 / 2^15, truncated toward minus infinity, then saturated.
  function automatic logic signed [WORKINGWIDTH-1:0] gain_sat(
    input logic signed [WORKINGWIDTH-1:0] v
  );
    logic signed [GW-1:0]           e;
    logic signed [GW-1:0]           p;
    logic signed [WORKINGWIDTH-1:0] r;
    e = {{16{v[WORKINGWIDTH-1]}}, v};
    p = (e * GAIN) >>> 15;
    if (p > GMAX) begin
      r = GMAX[WORKINGWIDTH-1:0];
    end else if (p < GMIN) begin
      r = GMIN[WORKINGWIDTH-1:0];
    end else begin
      r = p[WORKINGWIDTH-1:0];
    end
    return r;
  endfunction
`endif

  // Pipeline: index 0 is the quadrant-mapped input, index k+1 follows rotation k.
  logic signed [WORKINGWIDTH-1:0] x_d [NSTAGES+1];
  logic signed [WORKINGWIDTH-1:0] x_q [NSTAGES+1];
  logic signed [WORKINGWIDTH-1:0] y_d [NSTAGES+1];
  logic signed [WORKINGWIDTH-1:0] y_q [NSTAGES+1];
  logic signed [ZW-1:0]           z_d [NSTAGES];
  logic signed [ZW-1:0]           z_q [NSTAGES];
  logic                           v_d [NSTAGES+1];
  logic                           v_q [NSTAGES+1];

  logic [1:0]                     quad;
  logic [PHASEWIDTH-1:0]          res;
  logic signed [WORKINGWIDTH-1:0] amp_ext;
  logic signed [WORKINGWIDTH-1:0] amp_w;

  always_comb begin
    x_d = '{default: '0};
    y_d = '{default: '0};
    z_d = '{default: '0};
    v_d = '{default: 1'b0};

    // Rounding to the nearest quadrant: adding an eighth of a turn only
    // carries into the quadrant bits when the bit below them is set.
    quad    = 2'(phase_i[PHASEWIDTH-1:PHASEWIDTH-2] + {1'b0, phase_i[PHASEWIDTH-3]});
    res     = phase_i - {quad, {(PHASEWIDTH-2){1'b0}}};
    amp_ext = {{(WORKINGWIDTH-INPUTWIDTH){amp_i[INPUTWIDTH-1]}}, amp_i};
    amp_w   = amp_ext <<< PAD;

    case (quad)
      2'd0: begin x_d[0] = amp_w;  y_d[0] = '0;     end
      2'd1: begin x_d[0] = '0;     y_d[0] = amp_w;  end
      2'd2: begin x_d[0] = -amp_w; y_d[0] = '0;     end
      default: begin x_d[0] = '0;  y_d[0] = -amp_w; end
    endcase
    z_d[0] = {res[PHASEWIDTH-1], res};
    v_d[0] = valid_i;

    for (int k = 0; k < NSTAGES; k++) begin
      if (!z_q[k][ZW-1]) begin
        x_d[k+1] = x_q[k] - (y_q[k] >>> (k + 1));
        y_d[k+1] = y_q[k] + (x_q[k] >>> (k + 1));
      end else begin
        x_d[k+1] = x_q[k] + (y_q[k] >>> (k + 1));
        y_d[k+1] = y_q[k] - (x_q[k] >>> (k + 1));
      end
      v_d[k+1] = v_q[k];
    end

    // The residual after the last rotation is never needed.
    for (int k = 0; k < NSTAGES - 1; k++) begin
      if (!z_q[k][ZW-1]) begin
        z_d[k+1] = z_q[k] - angle_of(k);
      end else begin
        z_d[k+1] = z_q[k] + angle_of(k);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int k = 0; k <= NSTAGES; k++) begin
        x_q[k] <= '0;
        y_q[k] <= '0;
        v_q[k] <= 1'b0;
      end
      for (int k = 0; k < NSTAGES; k++) begin
        z_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k <= NSTAGES; k++) begin
        x_q[k] <= x_d[k];
        y_q[k] <= y_d[k];
        v_q[k] <= v_d[k];
      end
      for (int k = 0; k < NSTAGES; k++) begin
        z_q[k] <= z_d[k];
      end
    end
  end

  // Final x/y feeding the output register.
  logic signed [WORKINGWIDTH-1:0] fx;
  logic signed [WORKINGWIDTH-1:0] fy;
  logic                           fv;

`ifdef CORDIC_ROT_GAINCOMP_EN
  logic signed [WORKINGWIDTH-1:0] gx_d, gx_q;
  logic signed [WORKINGWIDTH-1:0] gy_d, gy_q;
  logic                           gv_d, gv_q;

  always_comb begin
    gx_d = gain_sat(x_q[NSTAGES]);
    gy_d = gain_sat(y_q[NSTAGES]);
    gv_d = v_q[NSTAGES];
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      gx_q <= '0;
      gy_q <= '0;
      gv_q <= 1'b0;
    end else begin
      gx_q <= gx_d;
      gy_q <= gy_d;
      gv_q <= gv_d;
    end
  end

  always_comb begin
    fx = gx_q;
    fy = gy_q;
    fv = gv_q;
  end
`else
  always_comb begin
    fx = x_q[NSTAGES];
    fy = y_q[NSTAGES];
    fv = v_q[NSTAGES];
  end
`endif

  logic signed [SIGNALBITS-1:0] i_d, i_q;
  logic signed [SIGNALBITS-1:0] q_d, q_q;
  logic                         vo_d, vo_q;

  always_comb begin
    i_d  = scale_sat(fx);
    q_d  = scale_sat(fy);
    vo_d = fv;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      i_q  <= '0;
      q_q  <= '0;
      vo_q <= 1'b0;
    end else begin
      i_q  <= i_d;
      q_q  <= q_d;
      vo_q <= vo_d;
    end
  end

  assign i_o     = i_q;
  assign q_o     = q_q;
  assign valid_o = vo_q;

endmodule

// File: tb/tb_red_pitaya_cordic_rot_block.sv
`timescale 1ns/1ps
module tb_red_pitaya_cordic_rot_block;

  localparam int SB   = 14;
  localparam int IW   = 14;
  localparam int WW   = 16;
  localparam int PW   = 12;
  localparam int NS   = 9;
  localparam int FULL = 1 << PW;
  localparam int QTR  = 1 << (PW - 2);
`ifdef CORDIC_ROT_GAINCOMP_EN
  localparam int LAT  = NS + 3;
`else
  localparam int LAT  = NS + 2;
`endif

  logic                 clk_i = 1'b0;
  logic                 rstn_i;
  logic [PW-1:0]        phase_i;
  logic signed [IW-1:0] amp_i;
  logic                 valid_i;
  logic signed [SB-1:0] i_o;
  logic signed [SB-1:0] q_o;
  logic                 valid_o;

  red_pitaya_cordic_rot_block dut (
    .clk_i   (clk_i),
    .rstn_i  (rstn_i),
    .phase_i (phase_i),
    .amp_i   (amp_i),
    .valid_i (valid_i),
    .i_o     (i_o),
    .q_o     (q_o),
    .valid_o (valid_o)
  );

  always #5 clk_i = ~clk_i;

  int n_vec = 0;
  int n_err = 0;

  // expected-output history, index 0 = most recently captured sample
  int hv [LAT];
  int hi [LAT];
  int hq [LAT];

  task automatic check_val(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int clamp(input int v, input int lo, input int hi_lim);
    if (v > hi_lim) return hi_lim;
    if (v < lo) return lo;
    return v;
  endfunction

  // Behavioural rotator: quadrant fold, then the micro-rotation recurrence with
  // angles computed from real arctangents.
  function automatic void model(input int ph, input int amp, output int ei, output int eq);
    int  n, z, x, y, a, t, ang;
    real r;
    n = ((ph + (FULL / 8)) / QTR) % 4;
    z = (ph - n * QTR + FULL) % FULL;
    if (z >= FULL / 2) z -= FULL;
    a = amp * (1 << (WW - IW - 2));
    x = (n == 0) ? a : (n == 2) ? -a : 0;
    y = (n == 1) ? a : (n == 3) ? -a : 0;
    for (int k = 0; k < NS; k++) begin
      r   = $floor((2.0 ** PW) * $atan(2.0 ** (-(k + 1))) / (2.0 * 3.14159265358979));
      ang = int'(r);
      if (z >= 0) begin
        t = x - (y >>> (k + 1)); y = y + (x >>> (k + 1)); x = t; z -= ang;
      end else begin
        t = x + (y >>> (k + 1)); y = y - (x >>> (k + 1)); x = t; z += ang;
      end
    end
`ifdef CORDIC_ROT_GAINCOMP_EN
    x = clamp((x * 28140) >>> 15, -(1 << (WW - 1)), (1 << (WW - 1)) - 1);
    y = clamp((y * 28140) >>> 15, -(1 << (WW - 1)), (1 << (WW - 1)) - 1);
`endif
    ei = clamp(x >>> (WW - IW - 2), -(1 << (SB - 1)), (1 << (SB - 1)) - 1);
    eq = clamp(y >>> (WW - IW - 2), -(1 << (SB - 1)), (1 << (SB - 1)) - 1);
  endfunction

  task automatic clear_hist();
    for (int k = 0; k < LAT; k++) begin
      hv[k] = 0; hi[k] = 0; hq[k] = 0;
    end
  endtask

  // One clock: capture the applied inputs into the model, then check outputs.
  task automatic step();
    int ei, eq;
    @(posedge clk_i);
    for (int k = LAT - 1; k > 0; k--) begin
      hv[k] = hv[k-1]; hi[k] = hi[k-1]; hq[k] = hq[k-1];
    end
    if (rstn_i && valid_i) begin
      model(int'(phase_i), int'(amp_i), ei, eq);
      hv[0] = 1; hi[0] = ei; hq[0] = eq;
    end else begin
      hv[0] = 0; hi[0] = 0; hq[0] = 0;
    end
    #1;
    check_val("valid_o", int'(valid_o), hv[LAT-1]);
    if (hv[LAT-1] != 0) begin
      check_val("i_o", int'(i_o), hi[LAT-1]);
      check_val("q_o", int'(q_o), hq[LAT-1]);
    end
  endtask

  task automatic drive(input int ph, input int amp, input logic v);
    phase_i = PW'(ph);
    amp_i   = IW'(amp);
    valid_i = v;
    step();
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_i"}, int'(i_o), 0);
    check_val({tag, "_q"}, int'(q_o), 0);
    check_val({tag, "_v"}, int'(valid_o), 0);
  endtask

  // Counts cycles from a single valid pulse to valid_o, bounded.
  task automatic latency_probe(input string tag, input int ph, input int amp);
    int cnt;
    drive(ph, amp, 1'b1);
    valid_i = 1'b0;
    cnt = 1;
    while (!valid_o && cnt < 4 * LAT) begin
      step();
      cnt++;
    end
    check_val(tag, cnt, LAT);
    step();
    check_val({tag, "_width"}, int'(valid_o), 0);
  endtask

  int dir_ph  [8] = '{'h400, 'hC00, 'h800, 'hFFF, 'h001, 'h200, 'h1FF, 'h600};
  int dir_amp [8] = '{4096, 4096, 8191, 4096, 4096, 4096, -8191, -8192};

  initial begin
    int cnt;
    clear_hist();
    rstn_i  = 1'b0;
    valid_i = 1'b0;
    phase_i = '0;
    amp_i   = '0;
    #12;
    check_reset_outputs("reset");
    repeat (2) step();
    rstn_i = 1'b1;
    repeat (2) drive(0, 0, 1'b0);

    // single pulse at 0 deg, then idle
    latency_probe("lat_pulse", 'h000, 4096);
    repeat (LAT + 2) drive(0, 0, 1'b0);

    // back-to-back directed points: axes, saturation, wrap edges, octant edges
    for (int k = 0; k < 8; k++) drive(dir_ph[k], dir_amp[k], 1'b1);
    repeat (LAT + 2) drive(0, 0, 1'b0);

    // random phase/amplitude with random valid gaps
    for (int k = 0; k < 400; k++)
      drive(int'($urandom_range(FULL - 1)), int'($urandom_range(16383)) - 8192,
            logic'($urandom_range(1)));

    // continuous phase sweep across two wraps
    for (int k = 0; k < 2 * FULL; k++) drive(k % FULL, 4096, 1'b1);

    // reset in the middle of a stream
    for (int k = 0; k < 20; k++)
      drive(int'($urandom_range(FULL - 1)), int'($urandom_range(16383)) - 8192, 1'b1);
    rstn_i = 1'b0;
    #1;
    check_reset_outputs("midreset");
    clear_hist();
    step();
    rstn_i  = 1'b1;
    valid_i = 1'b0;
    repeat (3) step();
    phase_i = PW'($urandom_range(FULL - 1));
    amp_i   = IW'($urandom_range(16383));
    valid_i = 1'b1;
    step();
    cnt = 1;
    while (!valid_o && cnt < 4 * LAT) begin
      drive(int'($urandom_range(FULL - 1)), int'($urandom_range(16383)) - 8192, 1'b1);
      cnt++;
    end
    check_val("lat_after_reset", cnt, LAT);
    repeat (10) drive(int'($urandom_range(FULL - 1)), 4096, 1'b1);
    repeat (LAT + 2) drive(0, 0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
